// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_pkg
// Brief  : Raster timing presets, timing struct and window helper functions.
// Rev    : 1.0
// ============================================================================
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } timing_t;

  localparam timing_t c_VGA640_H = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam timing_t c_VGA640_V = '{active: 480, fp: 10, sync: 2,   bp: 33};
  localparam timing_t c_SVGA800_H = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam timing_t c_SVGA800_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};

  function automatic int unsigned total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // Sync occupies the slot between the front and back porch.
  function automatic bit sync_window(timing_t t, int unsigned pos);
    return (pos >= t.active + t.fp) && (pos < t.active + t.fp + t.sync);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_gen_if
// Brief  : Enable input and raster outputs of the VGA timing generator.
// Rev    : 1.0
// ============================================================================
interface vga_timing_gen_if #(
  parameter int HW      = 10,
  parameter int VW      = 10,
  parameter int FRAME_W = 8
);
  logic               i_ena;
  logic               o_pix_stb;
  logic [HW-1:0]      o_hpos;
  logic [VW-1:0]      o_vpos;
  logic               o_display_on;
  logic               o_hsync;
  logic               o_vsync;
  logic               o_line_start;
  logic               o_frame_start;
  logic [FRAME_W-1:0] o_frame_cnt;

  modport master (
    input  i_ena,
    output o_pix_stb, o_hpos, o_vpos, o_display_on, o_hsync, o_vsync,
           o_line_start, o_frame_start, o_frame_cnt
  );

  modport slave (
    output i_ena,
    input  o_pix_stb, o_hpos, o_vpos, o_display_on, o_hsync, o_vsync,
           o_line_start, o_frame_start, o_frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module : vga_axis_counter
// Brief  : One raster axis: position counter with registered active/sync decode.
// Rev    : 1.0
// ============================================================================
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned LEN_ACTIVE = 640,
  parameter int unsigned FP         = 16,
  parameter int unsigned SYNC       = 96,
  parameter int unsigned BP         = 48,
  parameter bit          POL        = 1'b0,
  parameter int          W          = $clog2(LEN_ACTIVE + FP + SYNC + BP)
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         i_tick,
  output logic [W-1:0]      o_pos,
  output logic              o_active,
  output logic              o_sync,
  output logic              o_wrap
);

  localparam timing_t        c_T     = '{active: LEN_ACTIVE, fp: FP, sync: SYNC, bp: BP};
  localparam int unsigned    c_TOTAL = total(c_T);
  localparam logic [W-1:0]   c_LAST  = W'(c_TOTAL - 1);

  if (LEN_ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_timing
    $error("vga_axis_counter: every timing length must be >= 1");
  end

  logic [W-1:0] r_pos;
  logic         r_active;
  logic         r_sync;
  logic         w_wrap;
  logic [W-1:0] w_pos_nxt;

  assign w_wrap    = i_tick && (r_pos == c_LAST);
  assign w_pos_nxt = !i_tick ? r_pos : (w_wrap ? '0 : r_pos + 1'b1);

  // Decodes come from the next position so they line up with o_pos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos    <= c_LAST;
      r_active <= 1'b0;
      r_sync   <= !POL;
    end else begin
      r_pos    <= w_pos_nxt;
      r_active <= (w_pos_nxt < W'(LEN_ACTIVE));
      r_sync   <= sync_window(c_T, 32'(w_pos_nxt)) ? POL : !POL;
    end
  end

  assign o_pos    = r_pos;
  assign o_active = r_active;
  assign o_sync   = r_sync;
  assign o_wrap   = w_wrap;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_gen
// Brief  : Parametrised VGA raster generator with divider, strobes, frame count.
// Rev    : 1.0
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned FRAME_W   = 8
) (
  input wire logic           clk,
  input wire logic           rst_n,
  vga_timing_gen_if.master   bus
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV == 0 || FRAME_W == 0) begin : g_bad_params
    $error("vga_timing_gen: CLK_DIV and FRAME_W must be >= 1");
  end

  logic [DW-1:0]      r_div;
  logic               r_pix_stb;
  logic               r_line_start;
  logic               r_frame_start;
  logic               r_primed;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               w_div_wrap;
  logic               w_tick;
  logic               w_hwrap;
  logic               w_vwrap;
  logic               w_hactive;
  logic               w_vactive;

  assign w_div_wrap = (r_div == DW'(CLK_DIV - 1));
  assign w_tick     = bus.i_ena && w_div_wrap;

  vga_axis_counter #(
    .LEN_ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP),
    .POL (HSYNC_POL), .W (HW)
  ) u_h (
    .clk (clk), .rst_n (rst_n), .i_tick (w_tick),
    .o_pos (bus.o_hpos), .o_active (w_hactive), .o_sync (bus.o_hsync), .o_wrap (w_hwrap)
  );

  vga_axis_counter #(
    .LEN_ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP),
    .POL (VSYNC_POL), .W (VW)
  ) u_v (
    .clk (clk), .rst_n (rst_n), .i_tick (w_hwrap),
    .o_pos (bus.o_vpos), .o_active (w_vactive), .o_sync (bus.o_vsync), .o_wrap (w_vwrap)
  );

  // The wrap out of the reset back-porch point starts frame 0; it is not a completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_pix_stb     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_primed      <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      if (bus.i_ena) begin
        r_div <= w_div_wrap ? '0 : r_div + 1'b1;
      end
      r_pix_stb     <= w_tick;
      r_line_start  <= w_hwrap;
      r_frame_start <= w_vwrap;
      if (w_tick) begin
        r_primed <= 1'b1;
      end
      if (w_vwrap && r_primed) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign bus.o_pix_stb     = r_pix_stb;
  assign bus.o_line_start  = r_line_start;
  assign bus.o_frame_start = r_frame_start;
  assign bus.o_frame_cnt   = r_frame_cnt;
  assign bus.o_display_on  = w_hactive && w_vactive;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_timing_gen
// Brief  : Scoreboard bench for vga_timing_gen on a reduced raster, two configs.
// Rev    : 1.0
// ============================================================================
module tb_vga_timing_gen;

  localparam int H_A = 8, H_F = 2, H_S = 3, H_B = 2;
  localparam int V_A = 4, V_F = 1, V_S = 2, V_B = 1;
  localparam int HT  = 15, VT = 8;
  localparam int HWB = 4, VWB = 3, FW = 2;

  typedef struct {
    int div, h, v, fc;
    bit primed, pix, ls, fs;
  } mstate_t;

  typedef struct {
    int h, v, fc;
    bit pix, ls, fs, disp, hs, vs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  mstate_t ma, mb;
  exp_t    qa[$];
  exp_t    qb[$];

  vga_timing_gen_if #(.HW(HWB), .VW(VWB), .FRAME_W(FW)) ifa ();
  vga_timing_gen_if #(.HW(HWB), .VW(VWB), .FRAME_W(FW)) ifb ();

  vga_timing_gen #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1), .FRAME_W(FW)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  vga_timing_gen #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CLK_DIV(2), .FRAME_W(FW)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic mstate_t m_reset();
    mstate_t s;
    s.div = 0; s.h = HT - 1; s.v = VT - 1; s.fc = 0;
    s.primed = 0; s.pix = 0; s.ls = 0; s.fs = 0;
    return s;
  endfunction

  function automatic mstate_t m_step(mstate_t s, bit ena, int cdiv);
    mstate_t n = s;
    n.pix = 0; n.ls = 0; n.fs = 0;
    if (ena) begin
      if (s.div == cdiv - 1) begin
        n.div = 0; n.pix = 1; n.primed = 1;
        n.h = (s.h + 1) % HT;
        if (n.h == 0) begin
          n.ls = 1;
          n.v = (s.v + 1) % VT;
          if (n.v == 0) begin
            n.fs = 1;
            if (s.primed) n.fc = (s.fc + 1) % (1 << FW);
          end
        end
      end else begin
        n.div = s.div + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t m_out(mstate_t s, bit hpol, bit vpol);
    exp_t e;
    e.h = s.h; e.v = s.v; e.fc = s.fc;
    e.pix = s.pix; e.ls = s.ls; e.fs = s.fs;
    e.disp = (s.h < H_A) && (s.v < V_A);
    e.hs = (s.h >= H_A + H_F && s.h < H_A + H_F + H_S) ? hpol : !hpol;
    e.vs = (s.v >= V_A + V_F && s.v < V_A + V_F + V_S) ? vpol : !vpol;
    return e;
  endfunction

  always @(negedge rst_n) begin
    ma = m_reset();
    mb = m_reset();
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      ma = m_reset();
      mb = m_reset();
    end else begin
      ma = m_step(ma, ifa.i_ena, 1);
      mb = m_step(mb, ifb.i_ena, 2);
    end
    qa.push_back(m_out(ma, 1'b0, 1'b0));
    qb.push_back(m_out(mb, 1'b1, 1'b0));
  end

  task automatic sb_cmp(input string p, input exp_t e, input int h, input int v, input int fc,
                        input logic pix, input logic ls, input logic fs,
                        input logic disp, input logic hs, input logic vs);
    check({p, ".hpos"}, h, e.h);
    check({p, ".vpos"}, v, e.v);
    check({p, ".frame_cnt"}, fc, e.fc);
    check({p, ".pix_stb"}, pix, e.pix);
    check({p, ".line_start"}, ls, e.ls);
    check({p, ".frame_start"}, fs, e.fs);
    check({p, ".display_on"}, disp, e.disp);
    check({p, ".hsync"}, hs, e.hs);
    check({p, ".vsync"}, vs, e.vs);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      sb_cmp("a", e, int'(ifa.o_hpos), int'(ifa.o_vpos), int'(ifa.o_frame_cnt), ifa.o_pix_stb,
             ifa.o_line_start, ifa.o_frame_start, ifa.o_display_on, ifa.o_hsync, ifa.o_vsync);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      sb_cmp("b", e, int'(ifb.o_hpos), int'(ifb.o_vpos), int'(ifb.o_frame_cnt), ifb.o_pix_stb,
             ifb.o_line_start, ifb.o_frame_start, ifb.o_display_on, ifb.o_hsync, ifb.o_vsync);
    end
  end

  task automatic wait_fs_a(input string tag);
    @(negedge clk);
    for (int i = 0; i < 400 && !ifa.o_frame_start; i++) @(negedge clk);
    check(tag, ifa.o_frame_start, 1);
  endtask

  initial begin
    int t0;
    int cnt;
    int first;
    ma = m_reset();
    mb = m_reset();
    ifa.i_ena = 1'b1;
    ifb.i_ena = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst.hpos", ifa.o_hpos, HT - 1);
    check("rst.vpos", ifa.o_vpos, VT - 1);
    check("rst.hsync_a", ifa.o_hsync, 1);
    check("rst.hsync_b", ifb.o_hsync, 0);
    check("rst.vsync", ifa.o_vsync, 1);
    check("rst.display_on", ifa.o_display_on, 0);
    check("rst.frame_cnt", ifa.o_frame_cnt, 0);
    check("rst.pix_stb", ifa.o_pix_stb, 0);

    rst_n = 1'b1;
    @(negedge clk);
    check("first.hpos", ifa.o_hpos, 0);
    check("first.vpos", ifa.o_vpos, 0);
    check("first.frame_start", ifa.o_frame_start, 1);
    check("first.line_start", ifa.o_line_start, 1);
    check("first.display_on", ifa.o_display_on, 1);

    // Frame counter after three completed frames, then modulo wrap.
    for (int k = 0; k < 3; k++) wait_fs_a("frames.reach");
    check("frames.cnt3", ifa.o_frame_cnt, 3);
    wait_fs_a("frames.reach4");
    check("frames.cnt_wrap", ifa.o_frame_cnt, 0);

    // One line of hsync from a line start.
    @(negedge clk);
    for (int i = 0; i < 40 && !ifa.o_line_start; i++) @(negedge clk);
    check("hline.found", ifa.o_line_start, 1);
    cnt = 0; first = -1;
    for (int i = 0; i < HT; i++) begin
      if (ifa.o_hsync == 1'b0) begin
        cnt++;
        if (first < 0) first = int'(ifa.o_hpos);
      end
      if (ifa.o_hpos == 4'(H_A)) check("hline.disp_fall", ifa.o_display_on, 0);
      @(negedge clk);
    end
    check("hline.hsync_width", cnt, H_S);
    check("hline.hsync_first", first, H_A + H_F);
    check("hline.period", ifa.o_line_start, 1);

    // One frame of vsync from a frame start.
    wait_fs_a("vframe.found");
    cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (ifa.o_vsync == 1'b0) cnt++;
      @(negedge clk);
    end
    check("vframe.vsync_clks", cnt, V_S * HT);
    check("vframe.period", ifa.o_frame_start, 1);

    // Divided configuration: line period and one-clk strobe.
    for (int i = 0; i < 80 && !ifb.o_line_start; i++) @(negedge clk);
    check("b.line_found", ifb.o_line_start, 1);
    t0 = cyc;
    @(negedge clk);
    check("b.line_width", ifb.o_line_start, 0);
    for (int i = 0; i < 80 && !ifb.o_line_start; i++) @(negedge clk);
    check("b.line_period", cyc - t0, 2 * HT);

    // Enable gating on the undivided instance.
    for (int i = 0; i < 40 && ifa.o_hpos != 4'd5; i++) @(negedge clk);
    check("ena.reach", ifa.o_hpos, 5);
    ifa.i_ena = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("ena.hold_hpos", ifa.o_hpos, 5);
      check("ena.no_pix", ifa.o_pix_stb, 0);
    end
    ifa.i_ena = 1'b1;
    @(negedge clk);
    check("ena.resume", ifa.o_hpos, 6);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 200 && ifa.o_vpos != 3'd3; i++) @(negedge clk);
    check("mid.reach", ifa.o_vpos, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid.hpos", ifa.o_hpos, HT - 1);
    check("mid.vpos", ifa.o_vpos, VT - 1);
    check("mid.frame_cnt", ifa.o_frame_cnt, 0);
    check("mid.hsync", ifa.o_hsync, 1);
    check("mid.display_on", ifa.o_display_on, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid.first_fs", ifa.o_frame_start, 1);
    check("mid.first_hpos", ifa.o_hpos, 0);
    check("mid.first_vpos", ifa.o_vpos, 0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator for the tt_um_vga_ra_tt design family. It is the successor to the fixed 640x480 sync logic.
- Horizontal and vertical porch, sync and active lengths are parameters, as are the sync polarities and an integer pixel-clock divider.
- Adds an enable gate, a frame counter, and line-start and frame-start strobes.
- Sits between the top-level clk/rst_n and the pixel/colour pipeline. It drives hsync/vsync onto uo_out and supplies coordinates to the renderers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- CLK_DIV, 1, clk cycles per pixel (>=1)
- FRAME_W, 8, frame counter width
- Derived values: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters; HW = clog2(H_TOTAL); VW = clog2(V_TOTAL).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  advance enable; when low, all state holds
- pix_stb  out  1  one-clk pulse; marks the cycle in which the counters advance
- hpos  out  HW  current column, 0..H_TOTAL-1
- vpos  out  VW  current line, 0..V_TOTAL-1
- display_on  out  1  high while hpos<H_ACTIVE and vpos<V_ACTIVE
- hsync  out  1  horizontal sync, at HSYNC_POL level when active
- vsync  out  1  vertical sync, at VSYNC_POL level when active
- line_start  out  1  one-clk pulse when hpos becomes 0
- frame_start  out  1  one-clk pulse when (hpos,vpos) becomes (0,0)
- frame_cnt  out  FRAME_W  completed-frame count

Behaviour:
- Reset (async assert, sync release):
  - div counter = 0, pix_stb = 0.
  - hpos = H_TOTAL-1, vpos = V_TOTAL-1.
  - display_on = 0; hsync = !HSYNC_POL; vsync = !VSYNC_POL.
  - line_start = 0, frame_start = 0, frame_cnt = 0.
  - The reset state is a coherent back-porch point, so the first tick lands on (0,0).
- Divider:
  - The div counter increments on each clk with ena=1 and wraps at CLK_DIV-1.
  - pix_stb is registered; it is high for the clk cycle following the edge where the div counter wrapped.
  - With CLK_DIV=1 and ena=1, pix_stb is constantly 1 after the first cycle out of reset.
- Counters:
  - On a tick (internal wrap condition), hpos increments and wraps H_TOTAL-1 to 0.
  - On an hpos wrap, vpos increments and wraps V_TOTAL-1 to 0.
  - On a vpos wrap, frame_cnt increments; it is modulo 2^FRAME_W.
- Output registration:
  - All outputs are registered from the next-state counter values, so every decode is coherent with hpos/vpos in the same cycle (zero decode latency relative to the coordinates).
- Sync windows:
  - hsync is active for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync is active for vpos in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for whole lines, changing with the hpos 0 transition.
- Strobes:
  - line_start and frame_start are high for exactly one clk cycle, coincident with pix_stb, even when CLK_DIV>1.
  - frame_start implies line_start.
- ena=0:
  - Divider, counters, sync and display_on hold.
  - pix_stb, line_start and frame_start are forced to 0.
  - When ena rises again, counting resumes from the held div value.
- Reset mid-frame: everything returns immediately to the reset values; no partial line is emitted.
- Elaboration checks: CLK_DIV>=1, every timing parameter >=1, FRAME_W>=1.

Decomposition:
- Package vga_timing_pkg holds:
  - localparams for the 640x480@60 preset and an 800x600 preset;
  - a timing struct typedef (active, fp, sync, bp);
  - a function total() and a function sync_window().
- Sub-module vga_axis_counter(LEN_ACTIVE, FP, SYNC, BP, POL):
  - tick in; pos, active, sync and wrap out.
  - Instantiated twice: horizontal tick = pixel tick; vertical tick = horizontal wrap.

Test Plan:
1. Reset, defaults:
   - hold rst_n=0, ena=1 -> hpos=799, vpos=524, hsync=1, vsync=1, display_on=0, frame_cnt=0;
   - release -> first pix_stb gives hpos=0, vpos=0, frame_start=1, line_start=1, display_on=1.
2. Horizontal timing, defaults:
   - hsync=0 exactly for hpos 656..751 (96 cycles);
   - display_on falls at hpos=640;
   - line_start period = 800 clk.
3. Vertical timing:
   - vsync=0 for vpos 490..491 (1600 clk);
   - frame_start period = 420000 clk;
   - after 3 frames, frame_cnt=3.
4. CLK_DIV=2, HSYNC_POL=1:
   - pix_stb every 2nd clk;
   - line period 1600 clk;
   - hsync=1 only within hpos 656..751;
   - line_start width = 1 clk.
5. ena gating:
   - drop ena at hpos=100 for 50 clk -> hpos stays 100, no strobes;
   - resume -> next tick gives hpos=101.
6. Reset mid-frame at vpos=300:
   - all outputs return to the reset values asynchronously, frame_cnt=0;
   - after release, the first tick is (0,0) with frame_start=1.
